// File: rtl/lsm9ds1_pkg.sv
// lsm9ds1_pkg
// Shared definitions for the LSM9DS1 IMU SPI path: device select encoding,
// read/write flag values, the register addresses the driver uses most, the
// expected WHO_AM_I identities, and the address-byte builder.
package lsm9ds1_pkg;

    typedef enum logic {
        DEV_AG = 1'b0,
        DEV_M  = 1'b1
    } dev_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [6:0] WHO_AM_I    = 7'h0F;
    localparam logic [6:0] CTRL_REG1_G = 7'h10;
    localparam logic [6:0] CTRL_REG8   = 7'h22;
    localparam logic [6:0] OUT_X_L_M   = 7'h28;

    localparam logic [7:0] WHO_AM_I_AG_VAL = 8'h68;
    localparam logic [7:0] WHO_AM_I_M_VAL  = 8'h3D;

    // The magnetometer steals bit 6 of the address as its auto-increment
    // (MS) flag; the accel/gyro uses the full 7-bit address and relies on
    // CTRL_REG8.IF_ADD_INC for bursts.
    function automatic logic [7:0] addr_byte(input logic       rw,
                                             input dev_e       dev,
                                             input logic [6:0] addr,
                                             input logic [3:0] len_eff);
        logic [7:0] b;
        if (dev == DEV_M) begin
            b = {rw, (len_eff > 4'd1), addr[5:0]};
        end else begin
            b = {rw, addr};
        end
        return b;
    endfunction

endpackage

// File: rtl/lsm9ds1_spi_master_clk_div.sv
// spi_clk_div
// Half-period tick generator shared by the rover's SPI masters. A down-counter
// reloads with HALF-1 and pulses tick for one cycle at terminal count, so tick
// fires every HALF cycles. While restart is high the counter is held at the
// reload value and no tick is produced; the first tick after restart drops
// arrives exactly HALF cycles later.
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   restart  in   hold/realign the half-period timer
//   tick     out  one-cycle strobe at each half-period boundary
module spi_clk_div #(
    parameter int HALF = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int W = $clog2(HALF);
    localparam logic [W-1:0] RELOAD = W'(HALF - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt <= RELOAD;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0) && !restart;

endmodule

// File: rtl/lsm9ds1_spi_master.sv
// lsm9ds1_spi_master
// SPI mode-3 master for the LSM9DS1 IMU. Owns both chip selects, sends the
// address byte followed by 1..15 data bytes MSB first, pops write bytes from
// an upstream FWFT FIFO and returns read bytes as single-cycle strobes.
//   sclk, rst                  system clock, synchronous active-high reset
//   cmd_valid/ready            request handshake (ready only in IDLE)
//   cmd_rw/dev/addr/len        transaction descriptor, latched on accept
//   wr_data, wr_req            FIFO head and its pop strobe (same-cycle sample)
//   rd_data, rd_valid          received byte and its strobe
//   busy                       accept through end of GAP
//   spi_sck/mosi/miso          SPI bus, SCK idles high
//   spi_cs_ag_n, spi_cs_m_n    active-low selects for accel/gyro and mag
//
// state | meaning
// IDLE  | waiting for a command, selects high, SCK high
// SETUP | selected CS low, MOSI holds address MSB, H cycles
// SHIFT | 8*(len+1) SCK periods, low phase then high phase of H cycles each
// HOLD  | SCK high for H cycles before CS deasserts
// GAP   | both selects high for 2H cycles
module lsm9ds1_spi_master
    import lsm9ds1_pkg::*;
#(
    parameter int SYSCLK_FREQ = 100_000_000,
    parameter int SPI_FREQ    = 5_000_000
) (
    input  logic       sclk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic       cmd_dev,
    input  logic [6:0] cmd_addr,
    input  logic [3:0] cmd_len,
    input  logic [7:0] wr_data,
    output logic       wr_req,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_ag_n,
    output logic       spi_cs_m_n
);

    localparam int H = SYSCLK_FREQ / (2 * SPI_FREQ);

    if (H < 2) begin : g_bad_half_period
        $error("lsm9ds1_spi_master: SCK half-period below 2 system clocks");
    end

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_GAP   = 3'd4;

    logic [2:0] state;
    logic       rw_q;
    logic [3:0] len_q;
    logic [7:0] tx_sr;
    logic [7:0] rx_sr;
    logic [2:0] bit_cnt;
    logic [3:0] byte_cnt;
    logic       gap_second;
    logic       tick;
    logic       last_bit;
    logic       byte_end;
    logic       shift_fall;
    logic [3:0] len_eff_in;
    logic [7:0] ab;

    // Timer only runs outside IDLE, so every phase starts aligned to accept.
    spi_clk_div #(.HALF(H)) u_clk_div (
        .clk     (sclk),
        .rst     (rst),
        .restart (state == ST_IDLE),
        .tick    (tick)
    );

    assign len_eff_in = (cmd_len == 4'd0) ? 4'd1 : cmd_len;
    assign ab         = addr_byte(cmd_rw, dev_e'(cmd_dev), cmd_addr, len_eff_in);

    assign cmd_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign byte_end   = (bit_cnt == 3'd7);
    assign last_bit   = byte_end && (byte_cnt == len_q);
    assign shift_fall = (state == ST_SHIFT) && tick && spi_sck && !last_bit;

    // Combinational so the FIFO pops in the very cycle its head is loaded.
    assign wr_req = !rst && shift_fall && byte_end && (rw_q == RW_WRITE);

    always_ff @(posedge sclk) begin
        if (rst) begin
            state       <= ST_IDLE;
            rw_q        <= RW_WRITE;
            len_q       <= 4'd1;
            tx_sr       <= 8'h00;
            rx_sr       <= 8'h00;
            bit_cnt     <= 3'd0;
            byte_cnt    <= 4'd0;
            gap_second  <= 1'b0;
            spi_sck     <= 1'b1;
            spi_mosi    <= 1'b0;
            spi_cs_ag_n <= 1'b1;
            spi_cs_m_n  <= 1'b1;
            rd_data     <= 8'h00;
            rd_valid    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        rw_q        <= cmd_rw;
                        len_q       <= len_eff_in;
                        tx_sr       <= ab;
                        spi_mosi    <= ab[7];
                        spi_cs_ag_n <= cmd_dev;
                        spi_cs_m_n  <= !cmd_dev;
                        bit_cnt     <= 3'd0;
                        byte_cnt    <= 4'd0;
                        gap_second  <= 1'b0;
                        state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        spi_sck <= 1'b0;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (tick) begin
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            rx_sr   <= {rx_sr[6:0], spi_miso};
                            if (byte_end && (byte_cnt != 4'd0) && (rw_q == RW_READ)) begin
                                rd_data  <= {rx_sr[6:0], spi_miso};
                                rd_valid <= 1'b1;
                            end
                        end else if (last_bit) begin
                            state <= ST_HOLD;
                        end else begin
                            spi_sck <= 1'b0;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_end) begin
                                byte_cnt <= byte_cnt + 4'd1;
                                if (rw_q == RW_READ) begin
                                    tx_sr    <= 8'h00;
                                    spi_mosi <= 1'b0;
                                end else begin
                                    tx_sr    <= wr_data;
                                    spi_mosi <= wr_data[7];
                                end
                            end else begin
                                tx_sr    <= {tx_sr[6:0], 1'b0};
                                spi_mosi <= tx_sr[6];
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tick) begin
                        spi_cs_ag_n <= 1'b1;
                        spi_cs_m_n  <= 1'b1;
                        state       <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_second) begin
                            state <= ST_IDLE;
                        end else begin
                            gap_second <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsm9ds1_spi_master.sv
module tb_lsm9ds1_spi_master;
    import lsm9ds1_pkg::*;

    localparam int H     = 10;
    localparam int LIMIT = 5000;

    logic       sclk      = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw    = 1'b0;
    logic       cmd_dev   = 1'b0;
    logic [6:0] cmd_addr  = 7'h00;
    logic [3:0] cmd_len   = 4'd0;
    logic [7:0] wr_data   = 8'hEE;
    logic       spi_miso  = 1'b0;
    logic       cmd_ready, wr_req, rd_valid, busy;
    logic       spi_sck, spi_mosi, spi_cs_ag_n, spi_cs_m_n;
    logic [7:0] rd_data;

    always #5 sclk = ~sclk;

    lsm9ds1_spi_master #(.SYSCLK_FREQ(100_000_000), .SPI_FREQ(5_000_000)) dut (
        .sclk(sclk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rw(cmd_rw), .cmd_dev(cmd_dev), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_req(wr_req), .rd_data(rd_data), .rd_valid(rd_valid),
        .busy(busy), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_cs_ag_n(spi_cs_ag_n), .spi_cs_m_n(spi_cs_m_n)
    );

    typedef struct {
        logic         dev;
        logic         rw;
        logic [6:0]   addr;
        logic [3:0]   len;
        logic [119:0] data;
        logic [7:0]   exp_b0;
    } txn_t;

    txn_t vec[6];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cnt = 0, last_rise = 0, cs_rise_cyc = 0;
    int ag_low = 0, m_low = 0, both_low = 0, sck_idle_bad = 0, mosi_bad = 0;
    int wr_cnt = 0, rd_total = 0, rd_cnt = 0, last_rd_cyc = 0;
    logic [7:0]   mosi_cap[16];
    logic [119:0] resp = '0;
    logic [7:0]   fifo[$];
    logic [7:0]   sb[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bus monitor, MISO slave model, FIFO model and read scoreboard.
    initial begin
        logic p_sck, p_mosi, p_cs_low, p_wr_req, cs_low;
        logic [7:0] dummy, exp;
        int b;
        p_sck = 1'b1; p_mosi = 1'b0; p_cs_low = 1'b0; p_wr_req = 1'b0;
        for (int i = 0; i < 16; i++) mosi_cap[i] = 8'h00;
        forever begin
            @(posedge sclk);
            #1;
            cyc++;
            if (p_wr_req && fifo.size() > 0) dummy = fifo.pop_front();
            wr_data = (fifo.size() > 0) ? fifo[0] : 8'hEE;
            cs_low = !spi_cs_ag_n || !spi_cs_m_n;
            if (!spi_cs_ag_n && !spi_cs_m_n) both_low++;
            if (!spi_cs_ag_n) ag_low++;
            if (!spi_cs_m_n) m_low++;
            if (!cs_low && !spi_sck) sck_idle_bad++;
            if (cs_low && !p_cs_low) begin
                rise_cnt = 0;
                rd_cnt = 0;
                for (int i = 0; i < 16; i++) mosi_cap[i] = 8'h00;
            end
            if (!cs_low && p_cs_low) begin
                last_rise = rise_cnt;
                cs_rise_cyc = cyc;
            end
            if (cs_low && p_cs_low && (spi_mosi != p_mosi) && !(p_sck && !spi_sck)) mosi_bad++;
            if (cs_low && !p_sck && spi_sck && rise_cnt < 128) begin
                mosi_cap[rise_cnt / 8] = {mosi_cap[rise_cnt / 8][6:0], spi_mosi};
                rise_cnt++;
            end
            if (cs_low && p_sck && !spi_sck) begin
                if (rise_cnt >= 8 && rise_cnt < 128) begin
                    b = rise_cnt / 8 - 1;
                    spi_miso = resp[8 * b + 7 - (rise_cnt % 8)];
                end else begin
                    spi_miso = 1'b0;
                end
            end
            if (rd_valid) begin
                rd_total++;
                if (sb.size() == 0) begin
                    chk("rd_unexpected", int'(rd_data), -1);
                end else begin
                    exp = sb.pop_front();
                    chk("rd_data", int'(rd_data), int'(exp));
                end
                if (rd_cnt > 0) chk("rd_spacing", cyc - last_rd_cyc, 16 * H);
                rd_cnt++;
                last_rd_cyc = cyc;
            end
            if (wr_req) wr_cnt++;
            p_sck = spi_sck; p_mosi = spi_mosi; p_cs_low = cs_low; p_wr_req = wr_req;
        end
    end

    task automatic clear_stats();
        ag_low = 0; m_low = 0; both_low = 0; sck_idle_bad = 0; mosi_bad = 0;
        wr_cnt = 0; rd_total = 0;
    endtask

    task automatic run_txn(input txn_t t);
        int leff, n, acc;
        leff = (t.len == 4'd0) ? 1 : int'(t.len);
        resp = t.data;
        fifo.delete();
        for (int i = 0; i < leff; i++) begin
            if (t.rw) sb.push_back(t.data[8 * i +: 8]);
            else fifo.push_back(t.data[8 * i +: 8]);
        end
        clear_stats();
        @(negedge sclk);
        cmd_dev = t.dev; cmd_rw = t.rw; cmd_addr = t.addr; cmd_len = t.len;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < LIMIT) begin @(negedge sclk); n++; end
        acc = cyc;
        @(negedge sclk);
        cmd_valid = 1'b0;
        chk("accept_ready_low", int'(cmd_ready), 0);
        chk("accept_busy_high", int'(busy), 1);
        n = 0;
        while (!cmd_ready && n < LIMIT) begin @(negedge sclk); n++; end
        chk("done_in_bound", int'(n < LIMIT), 1);
        chk("duration", cyc - acc, 1 + 4 * H + 16 * H * (leff + 1));
        chk("mosi_addr", int'(mosi_cap[0]), int'(t.exp_b0));
        for (int i = 1; i <= leff; i++)
            chk("mosi_data", int'(mosi_cap[i]), t.rw ? 0 : int'(t.data[8 * (i - 1) +: 8]));
        chk("sck_rises", last_rise, 8 * (leff + 1));
        chk("cs_sel_low", t.dev ? m_low : ag_low, 2 * H + 16 * H * (leff + 1));
        chk("cs_other_low", t.dev ? ag_low : m_low, 0);
        chk("cs_both_low", both_low, 0);
        chk("mosi_off_fall", mosi_bad, 0);
        chk("sck_idle_high", sck_idle_bad, 0);
        chk("wr_req_count", wr_cnt, t.rw ? 0 : leff);
        chk("rd_valid_count", rd_total, t.rw ? leff : 0);
        chk("sb_empty", sb.size(), 0);
        if (t.rw) chk("rd_data_hold", int'(rd_data), int'(t.data[8 * (leff - 1) +: 8]));
    endtask

    initial begin
        int n, acc1, acc2;
        for (int v = 0; v < 6; v++) vec[v].data = '0;
        vec[0].dev = DEV_AG; vec[0].rw = RW_READ;  vec[0].addr = WHO_AM_I;    vec[0].len = 4'd1;
        vec[0].data[7:0] = WHO_AM_I_AG_VAL; vec[0].exp_b0 = 8'h8F;
        vec[1].dev = DEV_M;  vec[1].rw = RW_READ;  vec[1].addr = OUT_X_L_M;   vec[1].len = 4'd6;
        for (int i = 0; i < 6; i++) vec[1].data[8 * i +: 8] = 8'h11 + 8'(i);
        vec[1].exp_b0 = 8'hE8;
        vec[2].dev = DEV_AG; vec[2].rw = RW_WRITE; vec[2].addr = CTRL_REG1_G; vec[2].len = 4'd1;
        vec[2].data[7:0] = 8'hC0; vec[2].exp_b0 = 8'h10;
        vec[3].dev = DEV_M;  vec[3].rw = RW_READ;  vec[3].addr = WHO_AM_I;    vec[3].len = 4'd1;
        vec[3].data[7:0] = WHO_AM_I_M_VAL; vec[3].exp_b0 = 8'h8F;
        vec[4].dev = DEV_AG; vec[4].rw = RW_WRITE; vec[4].addr = CTRL_REG8;   vec[4].len = 4'd3;
        vec[4].data[23:0] = 24'h665544; vec[4].exp_b0 = 8'h22;
        vec[5].dev = DEV_M;  vec[5].rw = RW_WRITE; vec[5].addr = 7'h20;       vec[5].len = 4'd2;
        vec[5].data[15:0] = 16'h5AA5; vec[5].exp_b0 = 8'h60;

        // Reset values
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sck", int'(spi_sck), 1);
        chk("rst_mosi", int'(spi_mosi), 0);
        chk("rst_cs_ag", int'(spi_cs_ag_n), 1);
        chk("rst_cs_m", int'(spi_cs_m_n), 1);
        chk("rst_wr_req", int'(wr_req), 0);
        chk("rst_rd_valid", int'(rd_valid), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        @(negedge sclk);
        rst = 1'b0;
        @(posedge sclk);
        #1;
        chk("ready_after_release", int'(cmd_ready), 1);

        for (int v = 0; v < 6; v++) run_txn(vec[v]);

        // Reset in the middle of the address byte
        resp = '0; resp[7:0] = WHO_AM_I_AG_VAL;
        sb.push_back(WHO_AM_I_AG_VAL);
        clear_stats();
        @(negedge sclk);
        cmd_dev = DEV_AG; cmd_rw = RW_READ; cmd_addr = WHO_AM_I; cmd_len = 4'd1;
        cmd_valid = 1'b1;
        @(negedge sclk);
        cmd_valid = 1'b0;
        n = 0;
        while (rise_cnt < 3 && n < LIMIT) begin @(negedge sclk); n++; end
        chk("abort_third_rise", rise_cnt, 3);
        rst = 1'b1;
        @(posedge sclk);
        #1;
        chk("abort_cs_ag", int'(spi_cs_ag_n), 1);
        chk("abort_cs_m", int'(spi_cs_m_n), 1);
        chk("abort_sck", int'(spi_sck), 1);
        chk("abort_rd_valid", int'(rd_valid), 0);
        chk("abort_wr_req", int'(wr_req), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        repeat (2) @(posedge sclk);
        @(negedge sclk);
        rst = 1'b0;
        chk("abort_no_strobes", rd_total + wr_cnt, 0);
        sb.delete();
        run_txn(vec[0]);

        // Back-to-back with len=0: cmd_valid held high across both commands
        resp = '0; resp[7:0] = WHO_AM_I_AG_VAL;
        sb.push_back(WHO_AM_I_AG_VAL);
        sb.push_back(WHO_AM_I_AG_VAL);
        clear_stats();
        @(negedge sclk);
        cmd_dev = DEV_AG; cmd_rw = RW_READ; cmd_addr = WHO_AM_I; cmd_len = 4'd0;
        cmd_valid = 1'b1;
        acc1 = cyc;
        @(negedge sclk);
        n = 0;
        while (!cmd_ready && n < LIMIT) begin @(negedge sclk); n++; end
        acc2 = cyc;
        chk("b2b_first_duration", acc2 - acc1, 1 + 4 * H + 32 * H);
        chk("b2b_gap_after_cs", acc2 - cs_rise_cyc, 2 * H);
        chk("b2b_first_bits", last_rise, 16);
        @(negedge sclk);
        cmd_valid = 1'b0;
        chk("b2b_second_accepted", int'(busy), 1);
        n = 0;
        while (!cmd_ready && n < LIMIT) begin @(negedge sclk); n++; end
        chk("b2b_second_duration", cyc - acc2, 1 + 4 * H + 32 * H);
        chk("b2b_second_bits", last_rise, 16);
        chk("b2b_rd_count", rd_total, 2);
        chk("b2b_sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
